// File: rtl/eth_rx_pkg.sv
// Shared definitions for the Ethernet receive frame packer.
// Contents:
//   ETH_PREAMBLE / ETH_SFD  - preamble and start-of-frame delimiter bytes
//   CRC32_RESIDUE           - good-frame CRC residue (normal bit order)
//   eth_rx_state_t          - receive FSM states
//   eth_rx_entry_t          - output FIFO entry {data, sop, eop, err, length}
//   crc32_byte()            - reflected CRC-32 update by one byte
package eth_rx_pkg;

    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_DISCARD
    } eth_rx_state_t;

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic        err;
        logic [15:0] length;
    } eth_rx_entry_t;

    // LSB-first CRC-32 (poly 0x04C11DB7 reflected = 0xEDB88320)
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'h0, b};
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_rx_word_fifo.sv
// Synchronous first-word-fall-through FIFO of eth_rx_entry_t words.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (flushes contents)
//   i_push    - write i_wdata (ignored when full)
//   i_wdata   - entry to write
//   i_pop     - consume head entry (ignored when empty)
//   o_rdata   - head entry, valid while !o_empty
//   o_empty   - no entries stored
//   o_free    - number of free entries
module eth_rx_word_fifo
    import eth_rx_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  eth_rx_entry_t              i_wdata,
    input  logic                       i_pop,
    output eth_rx_entry_t              o_rdata,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_free
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    eth_rx_entry_t  r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic           w_do_push;
    logic           w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_free    = DEPTH_W - r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push && (r_count != DEPTH_W);
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/eth_rx_frame_packer.sv
// Ethernet receive frame packer: strips preamble/SFD from the PHY byte
// stream, packs frame bytes big-endian into 64-bit words and queues them
// on a valid/ready packet stream. Optional FCS check: ETH_RX_FCS_CHECK_EN.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   rx_data, rx_dv, rx_er     - PHY byte, carrier/valid, byte error
//   pkt_data_out              - word, first byte in [63:56], unused bytes 0
//   pkt_valid_out / pkt_ready_out - output handshake
//   pkt_sop, pkt_eop          - first / last word of frame
//   pkt_length                - frame bytes through this word
//   pkt_err                   - frame bad (eop beat only)
//   rx_frames, rx_runts, rx_oversize, rx_overflows, rx_errors - counters
//   rx_fcs_errors             - FCS failures (ETH_RX_FCS_CHECK_EN only)
module eth_rx_frame_packer
    import eth_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned MAX_FRAME  = 1522,
    parameter int unsigned MIN_FRAME  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_dv,
    input  logic                  rx_er,
    output logic [DATA_WIDTH-1:0] pkt_data_out,
    output logic                  pkt_valid_out,
    input  logic                  pkt_ready_out,
    output logic                  pkt_sop,
    output logic                  pkt_eop,
    output logic [15:0]           pkt_length,
    output logic                  pkt_err,
    output logic [31:0]           rx_frames,
    output logic [31:0]           rx_runts,
    output logic [31:0]           rx_oversize,
    output logic [31:0]           rx_overflows,
`ifdef ETH_RX_FCS_CHECK_EN
    output logic [31:0]           rx_errors,
    output logic [31:0]           rx_fcs_errors
`else
    output logic [31:0]           rx_errors
`endif
);

    localparam int unsigned FAW      = $clog2(FIFO_DEPTH);
    localparam logic [15:0] MAX_W    = 16'(MAX_FRAME);
    localparam logic [15:0] MIN_W    = 16'(MIN_FRAME);
    localparam logic [FAW:0] FREE_MIN = (FAW+1)'(2);

    eth_rx_state_t  r_state;
    logic           r_dv_prev;
    logic [15:0]    r_count;
    logic [63:0]    r_stage;
    logic           r_err;
    logic           r_sop_done;
    logic           r_push;
    eth_rx_entry_t  r_entry;
    logic [31:0]    r_rx_frames, r_rx_runts, r_rx_oversize, r_rx_overflows, r_rx_errors;

    eth_rx_entry_t  w_head;
    logic           w_empty;
    logic [FAW:0]   w_free;
    logic [FAW:0]   w_free_eff;
    logic           w_room;
    logic           w_held;
    logic           w_is_eop;
    logic           w_is_over;
    logic           w_end;
    logic           w_runt;
    logic           w_fcs_bad;
    logic           w_end_err;
    logic [63:0]    w_ins;

    eth_rx_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_push),
        .i_wdata (r_entry),
        .i_pop   (pkt_ready_out),
        .o_rdata (w_head),
        .o_empty (w_empty),
        .o_free  (w_free)
    );

    // Pushes are registered, so a pending push still occupies a slot.
    // At least two free slots keeps one in reserve for an overflow terminator.
    assign w_free_eff = w_free - {{FAW{1'b0}}, r_push};
    assign w_room     = (w_free_eff >= FREE_MIN);

    assign w_held    = (r_count != '0) && (r_count[2:0] == 3'd0);
    assign w_is_eop  = !rx_dv;
    assign w_is_over = rx_dv && (r_count == MAX_W);
    assign w_end     = w_is_eop || w_is_over;
    assign w_runt    = (r_count < MIN_W);
    assign w_end_err = r_err | w_is_over | (w_is_eop & (w_runt | w_fcs_bad));
    assign w_ins     = {rx_data, 56'h0} >> {r_count[2:0], 3'b000};

`ifdef ETH_RX_FCS_CHECK_EN
    logic [31:0] r_crc;
    logic [31:0] r_rx_fcs_errors;
    logic [31:0] w_crc_rev;
    // Register runs LSB-first; the residue constant is in normal bit order.
    assign w_crc_rev     = {<<{r_crc}};
    assign w_fcs_bad     = (w_crc_rev != CRC32_RESIDUE);
    assign rx_fcs_errors = r_rx_fcs_errors;
`else
    assign w_fcs_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            // Treat carrier as still up so a frame cut by reset is ignored.
            r_dv_prev      <= 1'b1;
            r_count        <= '0;
            r_stage        <= '0;
            r_err          <= 1'b0;
            r_sop_done     <= 1'b0;
            r_push         <= 1'b0;
            r_entry        <= '0;
            r_rx_frames    <= '0;
            r_rx_runts     <= '0;
            r_rx_oversize  <= '0;
            r_rx_overflows <= '0;
            r_rx_errors    <= '0;
`ifdef ETH_RX_FCS_CHECK_EN
            r_crc           <= '1;
            r_rx_fcs_errors <= '0;
`endif
        end else begin
            r_dv_prev <= rx_dv;
            r_push    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (rx_dv) begin
                        r_state <= (!r_dv_prev && rx_data == ETH_PREAMBLE) ? ST_PREAMBLE : ST_DISCARD;
                    end
                end
                ST_PREAMBLE: begin
                    if (!rx_dv) begin
                        r_state <= ST_IDLE;
                    end else if (rx_er) begin
                        r_state <= ST_DISCARD;
                    end else if (rx_data == ETH_SFD) begin
                        r_state    <= ST_DATA;
                        r_count    <= '0;
                        r_stage    <= '0;
                        r_err      <= 1'b0;
                        r_sop_done <= 1'b0;
`ifdef ETH_RX_FCS_CHECK_EN
                        r_crc      <= '1;
`endif
                    end else if (rx_data != ETH_PREAMBLE) begin
                        r_state <= ST_DISCARD;
                    end
                end
                ST_DATA: begin
                    if (w_is_eop && r_count == '0) begin
                        r_state    <= ST_IDLE;
                        r_rx_runts <= r_rx_runts + 32'd1;
                    end else if (w_end || w_held) begin
                        // The staged word leaves now: completed word, frame end or oversize cut.
                        if (w_room) begin
                            r_push     <= 1'b1;
                            r_entry    <= '{data: r_stage, sop: !r_sop_done, eop: w_end,
                                            err: w_end & w_end_err, length: r_count};
                            r_sop_done <= 1'b1;
                            if (w_end) begin
                                r_rx_frames <= r_rx_frames + 32'd1;
                                if (r_err)                r_rx_errors   <= r_rx_errors + 32'd1;
                                if (w_is_eop && w_runt)   r_rx_runts    <= r_rx_runts + 32'd1;
                                if (w_is_over)            r_rx_oversize <= r_rx_oversize + 32'd1;
`ifdef ETH_RX_FCS_CHECK_EN
                                if (w_is_eop && w_fcs_bad) r_rx_fcs_errors <= r_rx_fcs_errors + 32'd1;
`endif
                            end
                        end else begin
                            r_rx_overflows <= r_rx_overflows + 32'd1;
                            if (r_sop_done) begin
                                r_push      <= 1'b1;
                                r_entry     <= '{data: '0, sop: 1'b0, eop: 1'b1, err: 1'b1, length: r_count};
                                r_rx_frames <= r_rx_frames + 32'd1;
                                if (r_err) r_rx_errors <= r_rx_errors + 32'd1;
                            end
                        end
                        if (w_is_eop) begin
                            r_state <= ST_IDLE;
                        end else if (w_end || !w_room) begin
                            r_state <= ST_DISCARD;
                        end else begin
                            r_stage <= w_ins;
                            r_count <= r_count + 16'd1;
                            r_err   <= r_err | rx_er;
`ifdef ETH_RX_FCS_CHECK_EN
                            r_crc   <= crc32_byte(r_crc, rx_data);
`endif
                        end
                    end else begin
                        r_stage <= r_stage | w_ins;
                        r_count <= r_count + 16'd1;
                        r_err   <= r_err | rx_er;
`ifdef ETH_RX_FCS_CHECK_EN
                        r_crc   <= crc32_byte(r_crc, rx_data);
`endif
                    end
                end
                ST_DISCARD: begin
                    if (!rx_dv) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign pkt_valid_out = !w_empty;
    assign pkt_data_out  = w_empty ? '0 : w_head.data;
    assign pkt_sop       = !w_empty && w_head.sop;
    assign pkt_eop       = !w_empty && w_head.eop;
    assign pkt_err       = !w_empty && w_head.err;
    assign pkt_length    = w_empty ? '0 : w_head.length;

    assign rx_frames    = r_rx_frames;
    assign rx_runts     = r_rx_runts;
    assign rx_oversize  = r_rx_oversize;
    assign rx_overflows = r_rx_overflows;
    assign rx_errors    = r_rx_errors;

endmodule
